// File: rtl/cordic_seq_pkg.sv
// Shared types and width helpers for the CORDIC angle sequencer.
package cordic_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic int angle_width(input int fft_stage);
    return fft_stage - 1;
  endfunction

  function automatic int data_width(input int cr_stage_num);
    return cr_stage_num + 1;
  endfunction

endpackage

// File: rtl/cordic_seq_if.sv
// Result stream of the sequencer: one beat per swept angle, valid/ready handshake.
interface cordic_seq_if #(
  parameter int AW = 3,
  parameter int DW = 11
);
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_cos;
  logic [DW-1:0] out_sin;
  logic          out_cos_sign;
  logic [AW-1:0] out_index;
  logic          out_last;

  modport master (
    output out_valid, out_cos, out_sin, out_cos_sign, out_index, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_cos, out_sin, out_cos_sign, out_index, out_last,
    output out_ready
  );
endinterface

// File: rtl/cordic_seq_vld_pipe.sv
// Enable-gated delay line tracking which cordic pipeline slots hold a real issue,
// plus the angle index and last flag travelling with it. Flush clears every slot.
module cordic_seq_vld_pipe #(
  parameter int AW    = 3,
  parameter int DEPTH = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [AW-1:0] in_index,
  input  logic          in_last,
  output logic          out_valid,
  output logic [AW-1:0] out_index,
  output logic          out_last
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic          vld_reg;
      logic [AW-1:0] idx_reg;
      logic          last_reg;
      logic          vld_next;
      logic [AW-1:0] idx_next;
      logic          last_next;

      if (gi == 0) begin : g_head
        assign vld_next  = in_valid;
        assign idx_next  = in_index;
        assign last_next = in_last;
      end else begin : g_body
        assign vld_next  = g_stage[gi-1].vld_reg;
        assign idx_next  = g_stage[gi-1].idx_reg;
        assign last_next = g_stage[gi-1].last_reg;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_reg  <= 1'b0;
          idx_reg  <= '0;
          last_reg <= 1'b0;
        end else if (flush) begin
          vld_reg  <= 1'b0;
          idx_reg  <= '0;
          last_reg <= 1'b0;
        end else if (en) begin
          vld_reg  <= vld_next;
          idx_reg  <= idx_next;
          last_reg <= last_next;
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[DEPTH-1].vld_reg;
  assign out_index = g_stage[DEPTH-1].idx_reg;
  assign out_last  = g_stage[DEPTH-1].last_reg;

endmodule

// File: rtl/cordic_seq.sv
// Sweeps angle indices over [0, pi) into an external cordic_rot and streams its
// results back out with backpressure; the cordic pipeline stalls with the stream.
module cordic_seq
  import cordic_seq_pkg::*;
#(
  parameter int FFT_STAGE    = 4,
  parameter int CR_STAGE_NUM = 10,
  parameter int CR_LAT       = CR_STAGE_NUM,
  localparam int AW          = angle_width(FFT_STAGE),
  localparam int DW          = data_width(CR_STAGE_NUM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] step,
  output logic          busy,
  output logic          done,
  output logic          cr_cen,
  output logic [AW-1:0] cr_angle,
  input  logic [DW-1:0] cr_cos,
  input  logic [DW-1:0] cr_sin,
  input  logic          cr_cos_sign,
  cordic_seq_if.master  res
);

  state_t        state_reg;
  logic [AW-1:0] angle_reg;
  logic [AW-1:0] step_reg;
  logic          busy_reg;
  logic          done_reg;
  logic [AW:0]   angle_next;
  logic          issue_last;
  logic          head_valid;
  logic          head_last;
  logic [AW-1:0] head_index;
  logic          last_fire;

  // Carry out of the angle adder marks the final issue, so angles never wrap.
  assign angle_next = {1'b0, angle_reg} + {1'b0, step_reg};
  assign issue_last = angle_next[AW];
  assign cr_cen     = res.out_ready | ~head_valid;
  assign last_fire  = head_valid & res.out_ready & head_last;

  cordic_seq_vld_pipe #(
    .AW   (AW),
    .DEPTH(CR_LAT)
  ) u_vld_pipe (
    .clk      (clk),
    .rst      (rst),
    .en       (cr_cen),
    .flush    (abort),
    .in_valid (state_reg == ST_RUN),
    .in_index (angle_reg),
    .in_last  (issue_last),
    .out_valid(head_valid),
    .out_index(head_index),
    .out_last (head_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      angle_reg <= '0;
      step_reg  <= AW'(1);
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (abort && state_reg != ST_IDLE) begin
      state_reg <= ST_IDLE;
      angle_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (start && !abort) begin
            state_reg <= ST_RUN;
            angle_reg <= '0;
            step_reg  <= (step == '0) ? AW'(1) : step;
            busy_reg  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (cr_cen) begin
            if (issue_last) state_reg <= ST_DRAIN;
            else            angle_reg <= angle_next[AW-1:0];
          end
        end
        ST_DRAIN: begin
          if (last_fire) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy             = busy_reg;
  assign done             = done_reg;
  assign cr_angle         = angle_reg;
  assign res.out_valid    = head_valid;
  assign res.out_index    = head_index;
  assign res.out_last     = head_last;
  assign res.out_cos      = cr_cos;
  assign res.out_sin      = cr_sin;
  assign res.out_cos_sign = cr_cos_sign;

endmodule

// File: doc/cordic_seq.md
CORDIC_SEQ -- requirements
Module: cordic_seq

Interface
REQ-001 Parameter FFT_STAGE, default 4: FFT stage served; angle width AW = FFT_STAGE-1; sweep spans 2^AW angles over [0, pi).
REQ-002 Parameter CR_STAGE_NUM, default 10: attached cordic_rot depth; data width DW = CR_STAGE_NUM+1; results scaled by 2^CR_STAGE_NUM.
REQ-003 Parameter CR_LAT, default CR_STAGE_NUM: enabled cycles from angle presented to matching cordic result.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a sweep.
REQ-007 abort  in  1  cancel sweep and flush in-flight results.
REQ-008 step  in  AW  angle increment, sampled at accepted start; 0 treated as 1.
REQ-009 busy  out  1  sweep in progress.
REQ-010 done  out  1  one-cycle pulse after last beat accepted.
REQ-011 cr_cen  out  1  clock enable to cordic_rot.
REQ-012 cr_angle  out  AW  angle index to cordic_rot.
REQ-013 cr_cos, cr_sin  in  DW each  cordic magnitude results.
REQ-014 cr_cos_sign  in  1  cordic cosine sign.
REQ-015 out_valid / out_ready  out / in  1 each  result handshake; beat transfers when both high.
REQ-016 out_cos, out_sin  out  DW each; out_cos_sign  out  1; out_index  out  AW  angle of beat; out_last  out  1  final beat.

Function
REQ-017 FSM states IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE->RUN on start; captures step (0 -> 1); angle counter cleared.
REQ-019 RUN: each enabled cycle issues cr_angle = k*step, k = 0,1,...; final issue is largest k*step <= 2^AW-1; next cycle -> DRAIN.
REQ-020 Beat count = ceil(2^AW/step); no angle wraps past 2^AW-1.
REQ-021 Valid shift register, CR_LAT deep, advanced only when cr_cen=1, tracks in-flight issues with angle index and last flag.
REQ-022 out_valid = head entry valid; out_cos/out_sin/out_cos_sign taken directly from cordic; out_index/out_last from head entry.
REQ-023 cr_cen = out_ready OR NOT out_valid; when low, issue counter, shift register and cordic all hold.
REQ-024 Stalled outputs stay stable; no beat lost or duplicated.
REQ-025 DRAIN -> DONE when the out_last beat transfers; DONE asserts done for one cycle -> IDLE.
REQ-026 busy = 1 in RUN, DRAIN, DONE.
REQ-027 start while busy ignored; step changes during a sweep ignored.
REQ-028 abort in any non-IDLE state: next cycle IDLE, shift register cleared, out_valid=0, no done.
REQ-029 start and abort together: abort wins; state IDLE.
REQ-030 First out_valid exactly CR_LAT enabled cycles after first issue.

Reset
REQ-031 On rst: state IDLE; busy, done, out_valid, out_last = 0; cr_angle, out_index = 0; shift register cleared; cr_cen = 1.
REQ-032 rst mid-sweep takes effect immediately; no done; next start runs a full sweep.

Structure
REQ-033 Package cordic_seq_pkg holds state enum and AW/DW width helper functions.
REQ-034 Sub-module cordic_seq_vld_pipe: enable-gated CR_LAT-deep valid/index/last delay line with synchronous flush.
REQ-035 cordic_rot is not instantiated inside; top level connects cr_* ports.

Verification (FFT_STAGE=4, CR_STAGE_NUM=10, CR_LAT=10)
REQ-036 start, step=1, out_ready=1 -> angles 0..7 on consecutive cycles; 8 beats, index 0..7, out_last on 7, done 1 cycle later; signed cos/sin within 0.01 of cos/sin(j*pi/8) after /1024.
REQ-037 step=3 -> angles 0,3,6; 3 beats; out_last on index 6; step=0 -> same as step=1.
REQ-038 out_ready pattern 1,0,1,0 -> 8 unique beats in order; data stable on stalled cycles; cr_cen low exactly when out_valid=1 and out_ready=0.
REQ-039 abort after 4 issues -> next cycle busy=0, out_valid=0, no done; following start gives clean full 8-beat sweep.
REQ-040 start during DRAIN ignored; start+abort in IDLE -> stays IDLE, busy=0.
REQ-041 rst during DRAIN -> all outputs at reset values immediately; no done.
